// File: rtl/ssd_scan_ctrl.sv
// N-digit seven-segment scan controller: frame-synchronous double-buffered
// digits, per-digit enable, leading-zero blanking and PWM brightness.
module ssd_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 18,
  parameter int BRIGHT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  load_i,
  input  logic [N_DIGITS-1:0]   digit_en_i,
  input  logic                  blank_lz_i,
  input  logic [BRIGHT_W-1:0]   brightness_i,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [7:0]            cathodes_o,
  output logic                  frame_start_o
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);

  logic [SCAN_DIV-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [7:0]            cath_q, cath_d;
  logic                  fs_q, fs_d;
  logic                  wrap;
  logic [N_DIGITS:1]     lz;
  logic [N_DIGITS-1:0]   dark;
  logic [3:0]            nib;
  logic                  dp_sel, dark_sel, pwm_on;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b0000001;  4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;  4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;  4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;  4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;  4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;  default: hex7 = 7'b0111000;
    endcase
  endfunction

  // Slot counter; the digit index steps on the last clock of each slot.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    wrap  = 1'b0;
    if (&cnt_q) begin
      if (idx_q == '0) begin
        idx_d = LAST;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end
  end

  // A load on the wrap cycle lands in the active buffer for the new frame.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    if (load_i) begin
      pend_val_d = value_i;
      pend_dp_d  = dp_i;
    end
    if (wrap) begin
      act_val_d = pend_val_d;
      act_dp_d  = pend_dp_d;
    end
  end

  assign lz[N_DIGITS] = (act_val_q[4*(N_DIGITS-1) +: 4] == 4'h0);
  for (genvar d = 0; d < N_DIGITS; d++) begin : g_dig
    if (d == 0) begin : g_lsd
      assign dark[d] = ~digit_en_i[d];
    end else begin : g_hi
      if (d < N_DIGITS - 1) begin : g_chain
        assign lz[d + 1] = lz[d + 2] & (act_val_q[4*d +: 4] == 4'h0);
      end
      assign dark[d] = ~digit_en_i[d] | (blank_lz_i & lz[d + 1]);
    end
  end

  always_comb begin
    nib      = 4'h0;
    dp_sel   = 1'b0;
    dark_sel = 1'b1;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (idx_q == IW'(d)) begin
        nib      = act_val_q[4*d +: 4];
        dp_sel   = act_dp_q[d];
        dark_sel = dark[d];
      end
    end
    pwm_on = (cnt_q[SCAN_DIV-1 -: BRIGHT_W] <= brightness_i);
    an_d   = '1;
    cath_d = 8'hFF;
    if (pwm_on && !dark_sel) begin
      for (int d = 0; d < N_DIGITS; d++) begin
        if (idx_q == IW'(d)) an_d[d] = 1'b0;
      end
      cath_d = {hex7(nib), ~dp_sel};
    end
    fs_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= LAST;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      an_q       <= '1;
      cath_q     <= 8'hFF;
      fs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      an_q       <= an_d;
      cath_q     <= cath_d;
      fs_q       <= fs_d;
    end
  end

  assign an_o          = an_q;
  assign cathodes_o    = cath_q;
  assign frame_start_o = fs_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: position-based reference model checked every cycle,
// plus directed frames with hand-computed cathode/anode patterns.
module tb_ssd_scan_ctrl;
  localparam int N = 4, SD = 4, BW = 2;
  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] value = '0;
  logic [3:0] dp = '0, digit_en = 4'hF;
  logic load = 1'b0, blank_lz = 1'b0;
  logic [1:0] bright = 2'd3;
  logic [3:0] an;
  logic [7:0] cath;
  logic fs;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(SD), .BRIGHT_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .value_i(value), .dp_i(dp), .load_i(load),
    .digit_en_i(digit_en), .blank_lz_i(blank_lz), .brightness_i(bright),
    .an_o(an), .cathodes_o(cath), .frame_start_o(fs));

  // Model: pos = clocks since reset; 16-clock slots, leftmost digit first.
  int pos;
  logic [15:0] m_pv, m_av;
  logic [3:0] m_pd, m_ad;
  logic [3:0] exp_an;
  logic [7:0] exp_cath;
  logic exp_fs;

  function automatic int m_dig(int p);
    return 3 - (p / 16) % 4;
  endfunction

  function automatic logic m_lit(int p, logic [15:0] av);
    int d = m_dig(p);
    return digit_en[d] && !(blank_lz && d != 0 && (av >> (4 * d)) == 16'h0)
           && ((p % 16) / 4) <= int'(bright);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= 0; m_pv <= '0; m_av <= '0; m_pd <= '0; m_ad <= '0;
      exp_an <= 4'hF; exp_cath <= 8'hFF; exp_fs <= 1'b0;
    end else begin
      exp_an   <= m_lit(pos, m_av) ? ~(4'b0001 << m_dig(pos)) : 4'hF;
      exp_cath <= m_lit(pos, m_av) ?
                  {SEG[4'(m_av >> (4 * m_dig(pos)))], ~m_ad[m_dig(pos)]} : 8'hFF;
      exp_fs   <= (pos % 64) == 63;
      if (load) begin m_pv <= value; m_pd <= dp; end
      if ((pos % 64) == 63) begin
        m_av <= load ? value : m_pv;
        m_ad <= load ? dp : m_pd;
      end
      pos <= pos + 1;
    end
  end

  task automatic chk(string name, logic [7:0] got, logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model an", {4'h0, an}, {4'h0, exp_an});
    chk("model cath", cath, exp_cath);
    chk("model fs", {7'h0, fs}, {7'h0, exp_fs});
    chk("one anode", 8'($countones(~an) <= 1), 8'd1);
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(logic [15:0] v, logic [3:0] d);
    value = v; dp = d; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic wait_fs(string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = fs;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: frame_start not seen within 200 cycles", tag);
    end
  endtask

  // Called at a frame_start cycle; cs lists cathodes leftmost slot first, FF = dark.
  task automatic frame(string tag, logic [31:0] cs);
    for (int s = 0; s < 4; s++) begin
      logic [7:0] c = cs[8*(3-s) +: 8];
      logic [3:0] a = (c == 8'hFF) ? 4'hF : 4'(~(4'b0001 << (3 - s)));
      step(1);
      chk({tag, " an c0"}, {4'h0, an}, {4'h0, a});
      chk({tag, " cath c0"}, cath, c);
      step(7);
      chk({tag, " an c7"}, {4'h0, an}, {4'h0, a});
      step(8);
    end
  endtask

  task automatic pwm(string tag, int hi);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 16; c++) begin
        step(1);
        chk(tag, {4'h0, an}, {4'h0, (c <= hi) ? 4'(~(4'b0001 << (3 - s))) : 4'hF});
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(3);
    chk("reset an", {4'h0, an}, 8'h0F);
    chk("reset cath", cath, 8'hFF);
    chk("reset fs", {7'h0, fs}, 8'h00);
    rst_n = 1'b1;
    // Plain 1234
    do_load(16'h1234, 4'h0);
    wait_fs("t1"); frame("t1", 32'h9F250D99);
    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0050, 4'h0);
    wait_fs("t2a"); frame("t2a", 32'hFFFF4903);
    do_load(16'h0000, 4'h0);
    wait_fs("t2b"); frame("t2b", 32'hFFFFFF03);
    // PWM duty
    blank_lz = 1'b0; bright = 2'd1;
    do_load(16'h1234, 4'h0);
    wait_fs("t3a"); pwm("t3 b1", 7);
    bright = 2'd0;
    wait_fs("t3b"); pwm("t3 b0", 3);
    // Mid-frame load holds until the boundary
    bright = 2'd3;
    step(20);
    do_load(16'hABCD, 4'h0);
    step(12);
    chk("t4 hold cath", cath, 8'h0D);
    chk("t4 hold an", {4'h0, an}, 8'h0D);
    step(16);
    chk("t4 hold cath2", cath, 8'h99);
    wait_fs("t4a"); frame("t4a", 32'h11C16385);
    // Load on the boundary cycle
    step(63);
    value = 16'h1234; load = 1'b1;
    step(1);
    load = 1'b0;
    chk("t4 boundary fs", {7'h0, fs}, 8'h01);
    frame("t4b", 32'h9F250D99);
    // Digit enable and decimal points
    digit_en = 4'b1010;
    do_load(16'h1234, 4'b0010);
    wait_fs("t5"); frame("t5", 32'h9FFF0CFF);
    // Reset mid-slot
    digit_en = 4'hF;
    do_load(16'h1234, 4'h0);
    wait_fs("t6");
    step(25);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async an", {4'h0, an}, 8'h0F);
    chk("t6 async cath", cath, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      step(1);
      if (i == 1) begin
        chk("t6 first an", {4'h0, an}, 8'h07);
        chk("t6 first cath", cath, 8'h03);
      end
      chk("t6 fs", {7'h0, fs}, {7'h0, (i == 64)});
    end
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] msk;
      case ($urandom_range(0, 3))
        0: msk = 16'hFFFF; 1: msk = 16'h00FF; 2: msk = 16'h000F; default: msk = 16'h0000;
      endcase
      value = 16'($urandom) & msk;
      dp = 4'($urandom);
      load = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 63) == 0) bright = 2'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        step(1);
      end
    end
    load = 1'b0;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Parametrised N-digit seven-segment scan controller. It replaces the fixed 4-digit DIV_CLK-based scan and hex decode in our board tops. It adds frame-synchronous double-buffered value loading, per-digit enable, leading-zero blanking and PWM brightness. It sits between game/datapath logic and the board An*/Ca..Cg/Dp pins.

Parameters:
N_DIGITS, 4, number of digits, legal range 1..8
SCAN_DIV, 18, each digit slot lasts 2^SCAN_DIV clocks; must satisfy SCAN_DIV >= BRIGHT_W+1
BRIGHT_W, 3, width of the brightness control

Ports:
Clk  in  1  system clock (sys_clk, 100 MHz)
Reset  in  1  asynchronous, active-low reset
Value  in  4*N_DIGITS  hex nibbles; digit d = Value[4d+3:4d]; digit N_DIGITS-1 is leftmost
Dp_in  in  N_DIGITS  decimal point per digit, 1 = lit
Load  in  1  single-cycle pulse; captures Value and Dp_in into the pending buffer
Digit_en  in  N_DIGITS  1 = digit may light
Blank_lz  in  1  1 = suppress leading zeros
Brightness  in  BRIGHT_W  duty level; all-ones = full on
An  out  N_DIGITS  anodes, active-low, registered
Cathodes  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low, registered
Frame_start  out  1  one-cycle pulse when the scan wraps to the leftmost digit

Behaviour:
- Reset (Reset=0, asynchronous):
  - An = all ones, Cathodes = 8'hFF, Frame_start = 0.
  - Slot counter cnt = 0; digit index idx = N_DIGITS-1.
  - Pending and active buffers = 0.
- Scan:
  - cnt (SCAN_DIV bits) increments every clock.
  - When cnt is all ones, idx decrements on the same edge. From idx = 0 it wraps to N_DIGITS-1; that edge is the frame boundary.
- Frame boundary:
  - Active buffer <= pending buffer.
  - Frame_start = 1 for exactly the following cycle.
- Load:
  - Load=1 writes {Value, Dp_in} into pending.
  - If Load coincides with the frame-boundary cycle, the new data is written to both pending and active, so it shows in the frame that is starting.
  - The displayed value never changes mid-frame.
- Blanking: digit d is blanked if any of the following holds:
  - Digit_en[d] = 0.
  - Blank_lz = 1, d != 0, and active nibbles d..N_DIGITS-1 are all zero.
  - Digit 0 is never blanked by Blank_lz.
- PWM: with top = cnt[SCAN_DIV-1 -: BRIGHT_W], the current digit is lit only while top <= Brightness.
  - Level 0 gives a 1/2^BRIGHT_W duty.
  - Level all-ones gives full duty.
- Outputs, registered (one-cycle latency from cnt/idx):
  - Lit digit: An has only bit idx low. Cathodes = hex decode of the active nibble idx, with Dp bit = ~active_dp[idx].
  - Unlit (blanked or PWM off): An = all ones, Cathodes = 8'hFF.
- Hex decode, abcdefg active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, B=1100000
  - C=0110001, D=1000010, E=0110000, F=0111000
- Invariant: at most one An bit is low in any cycle.
- Reset mid-frame: outputs go dark immediately. After release, the scan restarts at the leftmost digit with zeroed buffers. The first Frame_start comes after N_DIGITS slots.

Test Plan:
All scenarios use N_DIGITS=4, SCAN_DIV=4, BRIGHT_W=2 (16-cycle slots, 64-cycle frame).
1. Release reset; Load Value=16'h1234, Dp_in=0, Digit_en=4'hF, Brightness=3 -> after the next Frame_start, An steps 0111, 1011, 1101, 1110 for 16 cycles each. Cathodes = 8'h9F, 8'h25, 8'h0D, 8'h99.
2. Blank_lz=1, Load 16'h0050 -> slots 3 and 2 give An=1111; slot 1 gives "5" (8'h49); slot 0 gives "0" (8'h03). Load 16'h0000 -> only slot 0 lit, showing 8'h03.
3. Brightness=1 -> each slot has An low for cycles 0-7 and 1111 for cycles 8-15. Brightness=0 -> low for 4 of 16 cycles.
4. Load 16'hABCD mid-frame while 16'h1234 is shown -> 1234 persists until Frame_start, then ABCD (8'h11, 8'hC1, 8'h63, 8'h85). Load on the boundary cycle -> the new value shows in the immediately starting frame.
5. Digit_en=4'b1010, Dp_in=4'b0010 -> slots 2 and 0 are dark. Slot 1 shows its Cathodes with Dp bit = 0. Slot 3 has Dp bit = 1.
6. Assert Reset mid-slot 2 -> An=4'hF and Cathodes=8'hFF in the same cycle. After release, An[3] is first low after one cycle of latency; Frame_start first rises 64 cycles later.
